// File: rtl/diag_readout_sequencer.sv
// Detector readout sequencer: settles each channel, averages 2^AVG_LOG2 ADC samples,
// and streams thresholded per-channel results over a valid/ready interface.
module diag_readout_sequencer #(
    parameter int N_CH        = 9,
    parameter int DATA_W      = 12,
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] thresh,
    output logic              busy,
    output logic              done,
    output logic [3:0]        adc_ch,
    output logic              adc_req,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_ch,
    output logic [DATA_W-1:0] res_avg,
    output logic              res_pos,
    output logic              res_err
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       CH_LAST     = 4'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_REQ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        ch_q, ch_d;
    logic [DATA_W-1:0] thresh_q, thresh_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] avg;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            thresh_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            thresh_q <= thresh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    // NOTE: every next-state signal is defaulted before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        thresh_d = thresh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    thresh_d = thresh;
                    ch_d     = '0;
                    acc_d    = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = S_REQ;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A sample arriving on the final timeout cycle still wins.
                if (adc_valid) begin
                    acc_d   = acc_q + ACC_W'(adc_data);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == LAST_SAMPLE) ? S_EMIT : S_REQ;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    acc_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (ch_q == CH_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d     = ch_q + 4'd1;
                        settle_d = '0;
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Truncating average: drop the AVG_LOG2 fractional bits of the sum.
    assign avg = acc_q[AVG_LOG2 +: DATA_W];

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign adc_ch    = ch_q;
    assign adc_req   = (state_q == S_REQ);
    assign res_valid = (state_q == S_EMIT);
    assign res_ch    = res_valid ? ch_q : 4'd0;
    assign res_avg   = (res_valid && !err_q) ? avg : '0;
    assign res_pos   = res_valid && !err_q && (avg >= thresh_q);
    assign res_err   = res_valid && err_q;

endmodule
